// File: rtl/lsu_mem_access_if.sv
// Core-side request/response and data-memory bus signals of the load/store unit.
// The slave modport is the LSU's view; master is the core plus memory environment.
interface lsu_mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// RV32I load/store unit: one access at a time over a req/ack word bus, with
// alignment checking, bus timeout, and sign/zero-extended load return.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  lsu_mem_access_if.slave lsu
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       lat_size, lat_size_d;
  logic             lat_unsigned, lat_unsigned_d;
  logic [1:0]       lat_lo, lat_lo_d;

  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;

  logic             req_err_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_c;

  // Alignment / size legality of the presented request
  always_comb begin
    req_err_c = 1'b0;
    case (lsu.req_size)
      2'b00:   req_err_c = 1'b0;
      2'b01:   req_err_c = lsu.req_addr[0];
      2'b10:   req_err_c = |lsu.req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    case (lsu.req_size)
      2'b00: begin
        be_c    = 4'(4'b0001 << lsu.req_addr[1:0]);
        wdata_c = {4{lsu.req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'(4'b0011 << {lsu.req_addr[1], 1'b0});
        wdata_c = {2{lsu.req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = lsu.req_wdata;
      end
    endcase
  end

  // Lane extraction and extension of returned read data
  assign rd_byte = lsu.bus_rdata[{lat_lo, 3'b000} +: 8];
  assign rd_half = lsu.bus_rdata[{lat_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_c = lsu.bus_rdata;
    case (lat_size)
      2'b00:   load_c = lat_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_c = lat_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_c = lsu.bus_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    lat_size_d     = lat_size;
    lat_unsigned_d = lat_unsigned;
    lat_lo_d       = lat_lo;
    req_ready_d    = req_ready_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = 32'h0;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;

    case (state)
      IDLE: begin
        req_ready_d = 1'b1;
        if (lsu.req_valid && req_ready_q) begin
          req_ready_d    = 1'b0;
          lat_size_d     = lsu.req_size;
          lat_unsigned_d = lsu.req_unsigned;
          lat_lo_d       = lsu.req_addr[1:0];
          if (req_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = lsu.req_we;
            bus_addr_d  = {lsu.req_addr[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (lsu.bus_ack) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus_we_q ? 32'h0 : load_c;
        end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        bus_req_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_lo       <= 2'b00;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'b0000;
      bus_wdata_q  <= 32'h0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      lat_size     <= lat_size_d;
      lat_unsigned <= lat_unsigned_d;
      lat_lo       <= lat_lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign lsu.req_ready  = req_ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_err   = resp_err_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.bus_req    = bus_req_q;
  assign lsu.bus_we     = bus_we_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_be     = bus_be_q;
  assign lsu.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed accesses, a bus responder that
// checks bus fields, and a response monitor comparing against queued expectations.
module tb_lsu_mem_access;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_access_if ifc();

  lsu_mem_access #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lsu  (ifc)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int n_resp  = 0;
  int n_exp   = 0;

  // Responder configuration, written by the stimulus process
  int          req_cnt        = 0;
  int          ack_wait       = 0;
  int          exp_req_cycles = 0;
  logic [31:0] mem_rdata      = 32'h0;
  logic        stray_ack      = 1'b0;
  logic        exp_we         = 1'b0;
  logic [3:0]  exp_be         = 4'h0;
  logic [31:0] exp_addr       = 32'h0;
  logic [31:0] exp_wdata      = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: checks bus fields every request cycle and acks after ack_wait waits
  always @(negedge clk) begin
    if (ifc.bus_req) begin
      if (exp_req_cycles == 0) begin
        check("bus_req_forbidden", 32'(ifc.bus_req), 32'd0);
      end else begin
        check("bus_addr",  ifc.bus_addr, exp_addr);
        check("bus_be",    32'(ifc.bus_be), 32'(exp_be));
        check("bus_we",    32'(ifc.bus_we), 32'(exp_we));
        check("bus_wdata", ifc.bus_wdata, exp_wdata);
      end
      req_cnt++;
      ifc.bus_ack   = (ack_wait >= 0) && (req_cnt == ack_wait + 1);
      ifc.bus_rdata = mem_rdata;
    end else begin
      if (req_cnt != 0) begin
        check("bus_req_cycles", 32'(req_cnt), 32'(exp_req_cycles));
        req_cnt = 0;
      end
      ifc.bus_ack   = stray_ack;
      ifc.bus_rdata = 32'hFFFF_FFFF;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.resp_valid === 1'b1) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", ifc.resp_rdata, e.rdata);
        check("resp_err", 32'(ifc.resp_err), 32'(e.err));
        check("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  // Present one request and hold it until accepted; returns 2ns after the accept edge
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int g;
    ifc.req_we       = we;
    ifc.req_size     = size;
    ifc.req_unsigned = uns;
    ifc.req_addr     = addr;
    ifc.req_wdata    = wdata;
    ifc.req_valid    = 1'b1;
    g = 0;
    while (ifc.req_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 50) check("accept_timeout", 32'(ifc.req_ready), 32'd1);
    @(posedge clk); #2;
    acc_cyc       = cyc;
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      check("resp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk); #2;
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata_bus, input int wait_n,
                     input logic [3:0] be, input logic [31:0] bwdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int req_cycles);
    exp_t e;
    exp_we         = we;
    exp_be         = be;
    exp_addr       = {addr[31:2], 2'b00};
    exp_wdata      = bwdata;
    ack_wait       = wait_n;
    mem_rdata      = rdata_bus;
    exp_req_cycles = req_cycles;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    n_exp++;
    issue(we, size, uns, addr, wdata);
    wait_drain();
  endtask

  initial begin
    rst_n            = 1'b0;
    ifc.req_valid    = 1'b0;
    ifc.req_we       = 1'b0;
    ifc.req_size     = 2'b00;
    ifc.req_unsigned = 1'b0;
    ifc.req_addr     = 32'h0;
    ifc.req_wdata    = 32'h0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready",  32'(ifc.req_ready), 32'd0);
    check("rst_bus_req",    32'(ifc.bus_req), 32'd0);
    check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rst_bus_addr",   ifc.bus_addr, 32'h0);
    check("rst_bus_be",     32'(ifc.bus_be), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_rst_req_ready", 32'(ifc.req_ready), 32'd1);

    //  we    size   uns   addr          wdata         bus_rdata     wait be     bus_wdata     rdata         err  lat cyc
    run(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0, 1, 1); // LB
    run(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'hBEEF_0001, 3, 4'hC, 32'h0,        32'h0000_BEEF, 1'b0, 4, 4); // LHU
    run(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5, 32'hDEAD_BEEF, 1, 4'h2, 32'hA5A5_A5A5, 32'h0,        1'b0, 2, 2); // SB
    run(1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1111_2222, 32'h0,        0, 4'h0, 32'h0,        32'h0,         1'b1, 0, 0); // SW misaligned
    run(1'b0, 2'b11, 1'b0, 32'h0000_7000, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,         1'b1, 0, 0); // size 11
    run(1'b0, 2'b01, 1'b0, 32'h0000_8002, 32'h0,        32'h8001_0000, 0, 4'hC, 32'h0,        32'hFFFF_8001, 1'b0, 1, 1); // LH
    run(1'b0, 2'b00, 1'b1, 32'h0000_9001, 32'h0,        32'h0000_F000, 0, 4'h2, 32'h0,        32'h0000_00F0, 1'b0, 1, 1); // LBU
    run(1'b1, 2'b01, 1'b0, 32'h0000_6001, 32'h0000_5555, 32'h0,        0, 4'h0, 32'h0,        32'h0,         1'b1, 0, 0); // SH misaligned
    run(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0,        32'h1234_5678, -1, 4'hF, 32'h0,       32'h0,         1'b1, TO, TO); // LW timeout

    // Late ack after the timeout must not start anything
    stray_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      check("stray_ack_bus_req", 32'(ifc.bus_req), 32'd0);
      check("stray_ack_ready",   32'(ifc.req_ready), 32'd1);
    end
    stray_ack = 1'b0;
    @(posedge clk); #2;

    // Reset while an LW is waiting on the bus
    exp_we         = 1'b0;
    exp_be         = 4'hF;
    exp_addr       = 32'h0000_5004;
    exp_wdata      = 32'h0;
    ack_wait       = -1;
    mem_rdata      = 32'h0;
    exp_req_cycles = 2;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("mid_rst_bus_req",   32'(ifc.bus_req), 32'd0);
    check("mid_rst_req_ready", 32'(ifc.req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("after_rst_req_ready", 32'(ifc.req_ready), 32'd1);

    run(1'b1, 2'b01, 1'b0, 32'h0000_6000, 32'hAAAA_1234, 32'h0,        0, 4'h3, 32'h1234_1234, 32'h0,        1'b0, 1, 1); // SH
    run(1'b0, 2'b10, 1'b1, 32'h0000_A000, 32'h0,        32'hCAFE_F00D, 2, 4'hF, 32'h0,        32'hCAFE_F00D, 1'b0, 3, 3); // LW

    repeat (3) @(posedge clk);
    #2;
    check("resp_count", 32'(n_resp), 32'(n_exp));
    check("sb_empty",   32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store unit sitting after the execution stage of the RV32I core. It takes the ALU result as the effective address and RF read-data-2 as store data. It runs one access at a time against a word-wide data-memory bus with a request/acknowledge handshake, and returns aligned, sign- or zero-extended load data or a completion/error indication to writeback. Misaligned accesses and bus timeouts are reported as errors and never reach the bus.

## Interface
- TIMEOUT, 255: maximum bus_req cycles without bus_ack before an error is raised; 0 disables the timeout.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit idle; accepts when req_valid && req_ready.
- req_we  in  1  1 = store (SB/SH/SW), 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU).
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (RF rd2), low bits significant.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size, or timeout.
- bus_req  out  1  memory request, held until bus_ack.
- bus_we  out  1  write strobe.
- bus_addr  out  32  {req_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables (write lanes; loads drive the lanes read).
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  memory completes the current request this cycle.
- bus_rdata  in  32  read word; valid when bus_ack=1 on a load.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. On accept, latch we/size/unsigned/addr/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11 → RESP with err=1. No bus cycle.
  - Otherwise → BUS.
- BUS: bus_req=1. All bus_* outputs hold stable. A cycle counter is cleared on entry.
  - bus_ack=1 → capture data, go to RESP with err=0.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 without ack → RESP with err=1. bus_req drops.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in BUS and RESP.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- bus_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte = bus_rdata[8*addr[1:0] +: 8]
  - half = bus_rdata[16*addr[1] +: 16]
  - Sign-extend from bit 7/15 unless unsigned. Word is passed through; unsigned is ignored.
- bus_ack outside BUS is ignored. req_valid outside IDLE is ignored; the core holds it.
- Reset values: state=IDLE, req_ready=0 during reset and 1 after. resp_valid=0, resp_err=0, resp_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, counter=0.
- Reset mid-access: the next edge with rst_n=0 returns to IDLE and drops bus_req. The in-flight access produces no response.

## Timing
- All outputs are registered. No combinational path from bus_ack/bus_rdata to resp_*, or from req_* to bus_*.
- Legal access accepted at edge T:
  - bus_req high from T+1.
  - If bus_ack is sampled at edge T+1+k, resp_valid is high during the cycle after that edge. Minimum latency is accept → resp_valid of 2 cycles.
- Error (misaligned) accepted at T: resp_valid with resp_err=1 in the cycle after T. bus_req is never asserted.
- Timeout: bus_req stays high for exactly TIMEOUT cycles, then resp_valid/resp_err=1 in the next cycle.
- Back-to-back: the next accept can occur in the cycle after resp_valid. Throughput is at most one access per 3 cycles.

## Test plan
- LB at addr 0x1003, bus_rdata=0x80FF_1234, ack at first bus_req cycle:
  - bus_be=0x8, bus_addr=0x1000.
  - resp_rdata=0xFFFF_FF80, err=0, 2 cycles after accept.
- LHU at 0x2002, bus_rdata=0xBEEF_0001, ack after 3 wait cycles:
  - bus_be=0xC, resp_rdata=0x0000_BEEF.
  - bus_req held 4 cycles with stable outputs.
- SB at 0x3001, wdata=0x1234_56A5:
  - bus_we=1, bus_be=0x2, bus_wdata=0xA5A5_A5A5.
  - resp_rdata=0, err=0.
- SW at 0x4002 (misaligned) and any access with size=11:
  - bus_req never asserts.
  - resp_valid=1 with resp_err=1 one cycle after accept.
- TIMEOUT=4, LW at 0x5000, bus_ack held 0:
  - bus_req high exactly 4 cycles, then resp_err=1.
  - A stray ack arriving later is ignored.
- rst_n driven low during BUS of an LW:
  - bus_req=0 and state IDLE after that edge, no resp_valid.
  - After rst_n rises, req_ready=1 and a new SH at 0x6000 completes normally (bus_be=0x3).
